// File: rtl/mlp_input_unpacker_pkg.sv
// Shared constants and FSM state encoding for the MLP input unpacker.
package mlp_input_unpacker_pkg;

  localparam int unsigned dataWidth       = 16;
  localparam int unsigned numWeightLayer1 = 784;
  localparam int unsigned IN_WIDTH_DEF    = 32;
  localparam int unsigned LANES           = IN_WIDTH_DEF / dataWidth;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    STREAM      = 3'd1,
    PAD         = 3'd2,
    DRAIN       = 3'd3,
    WAIT_RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/mlp_input_unpacker_lane_shifter.sv
// Holds one accepted beat and shifts it out one sample per cycle, lane 0 first.
module lane_shifter #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     load,
  input  logic                                     shift,
  input  logic [IN_WIDTH-1:0]                      din,
  output logic [DATA_WIDTH-1:0]                    head,
  output logic [$clog2(IN_WIDTH/DATA_WIDTH+1)-1:0] lanes_left
);

  localparam int unsigned N_LANES = IN_WIDTH / DATA_WIDTH;
  localparam int unsigned LW      = $clog2(N_LANES + 1);

  logic [IN_WIDTH-1:0] buffer;

  // A load in the same cycle as the final shift wins, giving bubble-free beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer     <= '0;
      lanes_left <= '0;
    end else if (load) begin
      buffer     <= din;
      lanes_left <= LW'(N_LANES);
    end else if (shift && lanes_left != '0) begin
      buffer     <= buffer >> DATA_WIDTH;
      lanes_left <= lanes_left - LW'(1);
    end
  end

  assign head = buffer[DATA_WIDTH-1:0];

endmodule

// File: rtl/mlp_input_unpacker.sv
// AXI-Stream to MLP sample unpacker with exact frame-length enforcement.
// MLP_INPUT_FRAME_GATE_EN: hold off the next frame until frame_done.
module mlp_input_unpacker
  import mlp_input_unpacker_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = dataWidth,
  parameter int unsigned FRAME_LEN  = numWeightLayer1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  frame_done,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  err_len
);

  localparam int unsigned N_LANES = IN_WIDTH / DATA_WIDTH;
  localparam int unsigned BEATS   = FRAME_LEN / N_LANES;
  localparam int unsigned LW      = $clog2(N_LANES + 1);
  localparam int unsigned BW      = $clog2(BEATS + 1);
  localparam int unsigned SW      = $clog2(FRAME_LEN + 1);

`ifdef MLP_INPUT_FRAME_GATE_EN
  localparam state_t FRAME_END = WAIT_RESULT;
`else
  localparam state_t FRAME_END = IDLE;
`endif

  state_t                state, next_state;
  logic [BW-1:0]         beat_cnt;
  logic [SW-1:0]         samp_cnt;
  logic                  last_seen;
  logic [LW-1:0]         lane_cnt;
  logic [DATA_WIDTH-1:0] lane_head;
  logic                  accept_c, load_c, shift_c, pad_c, drain_c;
  logic                  last_lane_c, frame_full_c, err_set_c;
  logic [BW-1:0]         next_beat_c;

  lane_shifter #(
    .IN_WIDTH  (IN_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .shift     (shift_c),
    .din       (s_axis_tdata),
    .head      (lane_head),
    .lanes_left(lane_cnt)
  );

  assign accept_c     = s_axis_tvalid && s_axis_tready;
  assign load_c       = accept_c && (state == IDLE || state == STREAM);
  assign shift_c      = (state == STREAM || state == DRAIN) && lane_cnt != '0;
  assign pad_c        = (state == PAD);
  assign last_lane_c  = shift_c && lane_cnt == LW'(1);
  assign frame_full_c = (shift_c || pad_c) && samp_cnt == SW'(FRAME_LEN - 1);
  assign next_beat_c  = (state == IDLE) ? BW'(1) : beat_cnt + BW'(1);
  assign drain_c      = !s_axis_tlast && next_beat_c == BW'(BEATS);

  // Ready depends only on registered state and the shifter occupancy.
  always_comb begin
    s_axis_tready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    s_axis_tready = 1'b1;
        STREAM:  s_axis_tready = lane_cnt <= LW'(1) && !last_seen && beat_cnt < BW'(BEATS);
        DRAIN:   s_axis_tready = lane_cnt == '0;
        default: s_axis_tready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    err_set_c  = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          next_state = drain_c ? DRAIN : STREAM;
          err_set_c  = drain_c;
        end
      end
      STREAM: begin
        if (accept_c) begin
          if (drain_c) begin
            next_state = DRAIN;
            err_set_c  = 1'b1;
          end
        end else if (last_lane_c && frame_full_c) begin
          next_state = FRAME_END;
        end else if (last_lane_c && last_seen) begin
          next_state = PAD;
          err_set_c  = 1'b1;
        end
      end
      PAD:         if (frame_full_c) next_state = FRAME_END;
      DRAIN:       if (accept_c && s_axis_tlast) next_state = FRAME_END;
      WAIT_RESULT: if (frame_done) next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // Frame counters, registered outputs and sticky length error (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      samp_cnt  <= '0;
      last_seen <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      busy      <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      if (load_c) begin
        beat_cnt  <= next_beat_c;
        last_seen <= s_axis_tlast;
      end
      if (accept_c && state == IDLE) samp_cnt <= '0;
      else if (shift_c || pad_c)     samp_cnt <= samp_cnt + SW'(1);
      m_valid <= shift_c || pad_c;
      if (shift_c)    m_data <= lane_head;
      else if (pad_c) m_data <= '0;
      busy    <= (next_state != IDLE);
      err_len <= err_set_c || (err_len && !err_clr);
    end
  end

endmodule

// File: tb/tb_mlp_input_unpacker.sv
// Randomized-data bench for mlp_input_unpacker with a frame-level reference model.
module tb_mlp_input_unpacker;

  localparam int unsigned IW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned FL = 8;
  localparam int unsigned NL = IW / DW;
  localparam int unsigned NB = FL / NL;

  logic          clk;
  logic          rst;
  logic [IW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          frame_done;
  logic          err_clr;
  logic          busy;
  logic          err_len;

  mlp_input_unpacker #(
    .IN_WIDTH  (IW),
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .frame_done   (frame_done),
    .err_clr      (err_clr),
    .busy         (busy),
    .err_len      (err_len)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [IW-1:0] beat_q[$];
  bit            last_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  bit            exp_err, drv_done, abort;
  int            pad_start, first_acc, first_out, last_out, extra_out, pad_rdy;
  int            gap_after, gap_len;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame of tl beats, tlast on the final one; expected output follows the framing rules.
  task automatic make_frame(input int tl, input bit seq);
    logic [IW-1:0] w;
    beat_q = {};
    last_q = {};
    exp_q  = {};
    for (int b = 0; b < tl; b++) begin
      if (seq) for (int l = 0; l < int'(NL); l++) w[l*DW +: DW] = DW'(b * int'(NL) + l + 1);
      else     w = $urandom();
      beat_q.push_back(w);
      last_q.push_back(b == tl - 1);
      if (b < int'(NB)) for (int l = 0; l < int'(NL); l++) exp_q.push_back(w[l*DW +: DW]);
    end
    pad_start = exp_q.size();
    while (exp_q.size() < int'(FL)) exp_q.push_back('0);
    exp_err = (tl != int'(NB));
  endtask

  task automatic drive();
    int t, lost;
    for (int b = 0; b < beat_q.size(); b++) begin
      if (abort) break;
      s_axis_tdata  = beat_q[b];
      s_axis_tlast  = last_q[b];
      s_axis_tvalid = 1'b1;
      t = 0;
      while (!s_axis_tready && !abort && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (abort) break;
      total++;
      assert (t < 200) else begin
        bad++;
        $error("FAIL beat_accept observed=stalled expected=accepted beat=%0d", b);
      end
      if (t >= 200) break;
      @(negedge clk);
      if (b == 0) first_acc = cyc;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (b + 1 == gap_after) begin
        lost = 0;
        t    = 0;
        while (lost < gap_len && t < 200) begin
          if (s_axis_tready) lost++;
          @(negedge clk);
          t++;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drv_done      = 1'b1;
  endtask

  task automatic monitor();
    int t, tail;
    got_q = {};
    extra_out = 0;
    pad_rdy   = 0;
    first_out = -1;
    last_out  = -1;
    t    = 0;
    tail = 0;
    while (t < 400 && tail < 4) begin
      @(negedge clk);
      t++;
      if (m_valid) begin
        if (got_q.size() < int'(FL)) begin
          got_q.push_back(m_data);
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
        end else begin
          extra_out++;
        end
      end
      if (got_q.size() >= pad_start && got_q.size() < int'(FL) && s_axis_tready) pad_rdy++;
      if (got_q.size() >= int'(FL) && drv_done) tail++;
    end
    chk("monitor_complete", 32'(t < 400), 32'(1));
  endtask

  task automatic run_frame();
    drv_done = 1'b0;
    fork
      drive();
      monitor();
    join
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), FL);
    for (int i = 0; i < int'(FL) && i < got_q.size(); i++)
      chk($sformatf("%s_s%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_err"}, 32'(err_len), 32'(exp_err));
    chk({tag, "_extra"}, 32'(extra_out), 32'(0));
    chk({tag, "_pad_ready"}, 32'(pad_rdy), 32'(0));
`ifdef MLP_INPUT_FRAME_GATE_EN
    chk({tag, "_busy_wait"}, 32'(busy), 32'(1));
`else
    chk({tag, "_busy_end"}, 32'(busy), 32'(0));
`endif
  endtask

  task automatic end_frame();
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'(0));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 32'(err_len), 32'(0));
  endtask

  initial begin
    int held, n, t;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    frame_done = 1'b0;
    err_clr    = 1'b0;
    abort      = 1'b0;
    drv_done   = 1'b1;
    gap_after  = 0;
    gap_len    = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(s_axis_tready), 32'(0));
    chk("rst_valid", 32'(m_valid), 32'(0));
    chk("rst_data", 32'(m_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_err", 32'(err_len), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(s_axis_tready), 32'(1));

    // Nominal frame 1..8
    make_frame(NB, 1'b1);
    run_frame();
    check_frame("nominal");
    chk("nominal_latency", 32'(first_out - first_acc), 32'(1));
    chk("nominal_span", 32'(last_out - first_out + 1), FL);
    end_frame();

    // Short and long frames
    make_frame(2, 1'b0);
    run_frame();
    check_frame("early");
    end_frame();
    make_frame(6, 1'b0);
    run_frame();
    check_frame("long");
    end_frame();

    for (int k = 0; k < 6; k++) begin
      make_frame(int'($urandom_range(1, NB + 3)), 1'b0);
      run_frame();
      check_frame($sformatf("rand%0d", k));
      end_frame();
    end

    // Next frame offered before frame_done
    make_frame(NB, 1'b0);
    run_frame();
    check_frame("gate_a");
`ifdef MLP_INPUT_FRAME_GATE_EN
    held = 0;
    s_axis_tdata  = beat_q[0];
    s_axis_tvalid = 1'b1;
    repeat (5) begin
      if (s_axis_tready) held++;
      @(negedge clk);
    end
    chk("gate_hold", 32'(held), 32'(0));
    frame_done = 1'b1;
    chk("gate_pulse_ready", 32'(s_axis_tready), 32'(0));
    @(negedge clk);
    frame_done = 1'b0;
    chk("gate_release_ready", 32'(s_axis_tready), 32'(1));
    s_axis_tvalid = 1'b0;
`else
    chk("ungated_ready", 32'(s_axis_tready), 32'(1));
`endif
    make_frame(NB, 1'b0);
    run_frame();
    check_frame("gate_b");
    end_frame();

    // Source stalls for three accept opportunities after beat 2
    gap_after = 2;
    gap_len   = 3;
    make_frame(NB, 1'b1);
    run_frame();
    check_frame("stall");
    chk("stall_span", 32'(last_out - first_out + 1), FL + 3);
    gap_after = 0;
    gap_len   = 0;
    end_frame();

    // Reset after five samples
    make_frame(NB, 1'b1);
    drv_done = 1'b0;
    fork
      drive();
      begin
        n = 0;
        t = 0;
        while (n < 5 && t < 200) begin
          @(negedge clk);
          t++;
          if (m_valid) n++;
        end
        chk("midrst_samples", 32'(n), 32'(5));
        rst   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(m_valid), 32'(0));
        chk("midrst_data", 32'(m_data), 32'(0));
        chk("midrst_ready", 32'(s_axis_tready), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_err", 32'(err_len), 32'(0));
      end
    join
    rst   = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    make_frame(NB, 1'b1);
    run_frame();
    check_frame("after_rst");
    end_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
